match_qual13: RTL

MATCH_QUAL13 -- requirements
Module: match_qual13

---
 rtl/match_qual13.sv | 119 +++++++++++
 1 files changed

// File: rtl/match_qual13.sv
// Debounced qualifier for a 13-input AND match term: M must be seen high on
// STABLE_CNT consecutive enabled edges before Q asserts. Counts qualifications in HC.
//   state | meaning
//   IDLE  | waiting for the first enabled M=1 sample
//   QUAL  | counting consecutive enabled M=1 samples (BUSY=1)
//   HELD  | match qualified (Q=1) until an enabled M=0 sample
module match_qual13 #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned HIT_W      = 8
) (
    input  logic             CK,
    input  logic             CDN,
    input  logic             CE,
    input  logic             M,
    input  logic             CLR,
    output logic             Q,
    output logic             P,
    output logic [HIT_W-1:0] HC,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE_CNT);

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_inc;
    logic               q_q;
    logic               p_q;
    logic               busy_q;
    logic [HIT_W-1:0]   hc_q;
    logic [HIT_W-1:0]   hc_d;
    logic               enter_held;

    always_comb begin
        cnt_inc    = cnt_q + 4'd1;
        enter_held = 1'b0;
        if (CE && M) begin
            case (state_q)
                IDLE:    enter_held = (STABLE_CNT == 1);
                QUAL:    enter_held = (cnt_inc == STABLE_C);
                default: enter_held = 1'b0;
            endcase
        end
        // CLR wins over a same-edge qualification; the count saturates at all-ones.
        hc_d = hc_q;
        if (CLR)
            hc_d = '0;
        else if (enter_held && (hc_q != {HIT_W{1'b1}}))
            hc_d = hc_q + HIT_W'(1);
    end

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            q_q     <= 1'b0;
            p_q     <= 1'b0;
            busy_q  <= 1'b0;
            hc_q    <= '0;
        end else begin
            p_q  <= enter_held;
            hc_q <= hc_d;
            if (CE) begin
                case (state_q)
                    IDLE: begin
                        if (M) begin
                            cnt_q <= 4'd1;
                            if (STABLE_CNT == 1) begin
                                state_q <= HELD;
                                q_q     <= 1'b1;
                            end else begin
                                state_q <= QUAL;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= 4'd0;
                        end
                    end
                    QUAL: begin
                        if (M) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == STABLE_C) begin
                                state_q <= HELD;
                                q_q     <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                        end
                    end
                    HELD: begin
                        // Release is immediate; no debounce on the falling side.
                        if (!M) begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                            q_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        q_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q    = q_q;
    assign P    = p_q;
    assign HC   = hc_q;
    assign BUSY = busy_q;

endmodule
